// File: rtl/oversampled_frame_rx_pkg.sv
// Shared types and constants for the oversampled serial frame receiver.
// Holds the receiver state encoding and the counter width helper.
package oversampled_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int CLK_DIV_40K         = 1250;
    localparam int SAMPLES_PER_BIT_DEF = 10;
    localparam int CODE_BITS_DEF       = 8;

    // Number of bits needed to hold the values 0..n-1 (never less than one).
    function automatic int width_for(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/oversampled_frame_rx_tick_divider.sv
// Free-running divider that produces a one-clock sample tick every DIV clocks.
// The count is never restarted by frame activity, only by reset.
module tick_divider
    import oversampled_frame_rx_pkg::*;
#(
    parameter int DIV = CLK_DIV_40K
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = width_for(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // tick is high during the clock in which the counter sits at zero
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/oversampled_frame_rx.sv
// Oversampling serial frame receiver: start bit, CODE_BITS data bits (MSB first),
// stop bit, each bit decided by a majority vote over SAMPLES_PER_BIT ticks.
module oversampled_frame_rx
    import oversampled_frame_rx_pkg::*;
#(
    parameter int   CLK_DIV         = CLK_DIV_40K,
    parameter int   SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
    parameter int   CODE_BITS       = CODE_BITS_DEF,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [CODE_BITS-1:0] code,
    output logic                 code_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int OW = width_for(SAMPLES_PER_BIT + 1);
    localparam int SW = width_for(SAMPLES_PER_BIT);
    localparam int BW = width_for(CODE_BITS);

    localparam logic [OW-1:0] HALF        = OW'(SAMPLES_PER_BIT / 2);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(CODE_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 tick;
    rx_state_t            state;
    logic [OW-1:0]        ones;
    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [CODE_BITS-1:0] shift_reg;

    logic [OW-1:0]        ones_next;
    logic                 window_close;
    logic                 vote;
    logic [CODE_BITS-1:0] shift_next;

    tick_divider #(
        .DIV (CLK_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .tick     (tick)
    );

    // Two-flop synchroniser; idles at the line's rest level so reset looks like no activity
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= IDLE_LEVEL;
            rx_s    <= IDLE_LEVEL;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        ones_next    = ones + {{(OW-1){1'b0}}, rx_s};
        window_close = (sample_cnt == LAST_SAMPLE);
        vote         = (ones_next > HALF);
        shift_next   = '0;
        shift_next[0] = vote;
        for (int i = 1; i < CODE_BITS; i++) begin
            shift_next[i] = shift_reg[i-1];
        end
    end

    // Everything advances on the sample tick; the strobes default low every clock
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ones       <= '0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (tick) begin
                if (state == IDLE) begin
                    // The detecting tick is already the first sample of the start window
                    if (rx_s != IDLE_LEVEL) begin
                        state      <= START;
                        busy       <= 1'b1;
                        ones       <= {{(OW-1){1'b0}}, rx_s};
                        sample_cnt <= SW'(1);
                    end
                end else if (window_close) begin
                    ones       <= '0;
                    sample_cnt <= '0;
                    case (state)
                        START: begin
                            if (vote == ~IDLE_LEVEL) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        DATA: begin
                            shift_reg <= shift_next;
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                        STOP: begin
                            if (vote == IDLE_LEVEL) begin
                                code       <= shift_reg;
                                code_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                        default: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end else begin
                    ones       <= ones_next;
                    sample_cnt <= sample_cnt + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_oversampled_frame_rx.sv
// Self-checking bench for oversampled_frame_rx: table-driven frames, hand-written
// corner sequences and randomized frames checked against a sample-array reference model.
module tb_oversampled_frame_rx;

    localparam int   CLK_DIV = 4;
    localparam int   SPB     = 10;
    localparam int   CB      = 8;
    localparam logic IDLE    = 1'b0;

    logic          clk;
    logic          rst_n;
    logic          rx_in;
    logic [CB-1:0] code;
    logic          code_valid;
    logic          frame_err;
    logic          busy;

    oversampled_frame_rx #(
        .CLK_DIV         (CLK_DIV),
        .SAMPLES_PER_BIT (SPB),
        .CODE_BITS       (CB),
        .IDLE_LEVEL      (IDLE)
    ) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [CB-1:0] code;
    } ev_t;

    typedef struct {
        int          slot;
        bit          is_err;
        logic [CB-1:0] code;
    } exp_t;

    typedef struct {
        string         name;
        logic [CB-1:0] data;
        bit            stop_bit;
        int            ninv_all;
        int            ninv_b7;
        int            exp_valid;
        int            exp_err;
        logic [CB-1:0] exp_code;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   e0    = 0;
    int   both_cnt = 0;
    bit   stim[$];
    ev_t  evq[$];
    exp_t expq[$];
    vec_t vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One record per strobe clock; a stretched pulse shows up as extra events
    always @(negedge clk) begin
        ev_t ev;
        if (rst_n) begin
            if (code_valid && frame_err) both_cnt++;
            if (code_valid || frame_err) begin
                ev.cyc    = cyc;
                ev.is_err = frame_err;
                ev.code   = code;
                evq.push_back(ev);
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) stim.push_back(IDLE);
    endtask

    // One bit window with its last ninv samples inverted
    task automatic addBit(input bit b, input int ninv);
        for (int s = 0; s < SPB; s++) stim.push_back((s >= SPB - ninv) ? ~b : b);
    endtask

    task automatic addFrame(input logic [CB-1:0] d, input bit stop_bit, input int ninv, input int ninv_b7);
        addBit(~IDLE, ninv);
        for (int i = CB - 1; i >= 0; i--) addBit(d[i], (i == CB - 1 && ninv_b7 > 0) ? ninv_b7 : ninv);
        addBit(stop_bit, ninv);
    endtask

    task automatic addWindowFlips(input bit b, input int k);
        bit w[SPB];
        int p;
        for (int s = 0; s < SPB; s++) w[s] = b;
        for (int j = 0; j < k; j++) begin
            p = $urandom_range(0, SPB - 1);
            w[p] = ~w[p];
        end
        for (int s = 0; s < SPB; s++) stim.push_back(w[s]);
    endtask

    // Each stim entry is held for exactly one tick period
    task automatic driveSlots(input int first, input int last);
        for (int i = first; i < last; i++) begin
            rx_in = stim[i];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus();
        evq.delete();
        both_cnt = 0;
        @(posedge clk);
        #1;
        e0 = cyc;
        driveSlots(0, stim.size());
        rx_in = IDLE;
        repeat (2 * CLK_DIV) @(posedge clk);
        #1;
    endtask

    function automatic bit voteAt(input int p);
        int ones;
        ones = 0;
        for (int s = 0; s < SPB; s++) ones += int'(stim[p + s]);
        return ones > SPB / 2;
    endfunction

    // Walks the sample array as a receiver would, one whole bit window at a time
    function automatic void modelDecode();
        int i;
        int pos;
        bit ok;
        logic [CB-1:0] d;
        exp_t e;
        expq.delete();
        i = 0;
        while (i < stim.size()) begin
            if (stim[i] == IDLE) begin
                i++;
            end else if (i + SPB > stim.size()) begin
                break;
            end else if (voteAt(i) != ~IDLE) begin
                i += SPB;
            end else begin
                pos = i + SPB;
                d = '0;
                ok = 1'b1;
                for (int b = 0; b < CB; b++) begin
                    if (pos + SPB > stim.size()) ok = 1'b0;
                    else d = {d[CB-2:0], voteAt(pos)};
                    pos += SPB;
                end
                if (!ok || pos + SPB > stim.size()) break;
                e.slot   = pos + SPB - 1;
                e.is_err = (voteAt(pos) != IDLE);
                e.code   = d;
                expq.push_back(e);
                i = pos + SPB;
            end
        end
    endfunction

    // A sample taken from slot k is acted on at posedge e0+4k+3 .. e0+4k+6
    task automatic compareWithModel(input string tag);
        int n;
        modelDecode();
        checkOutput($sformatf("%s event count", tag), evq.size(), expq.size());
        checkOutput($sformatf("%s both strobes high", tag), both_cnt, 0);
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s ev%0d kind", tag, i), int'(evq[i].is_err), int'(expq[i].is_err));
            checkOutput($sformatf("%s ev%0d slot", tag, i), (evq[i].cyc - e0 - 3) / CLK_DIV, expq[i].slot);
            if (!expq[i].is_err)
                checkOutput($sformatf("%s ev%0d code", tag, i), int'(evq[i].code), int'(expq[i].code));
        end
    endtask

    function automatic int countKind(input bit want_err);
        int c;
        c = 0;
        foreach (evq[i]) if (evq[i].is_err == want_err) c++;
        return c;
    endfunction

    initial begin
        int t0;
        logic [CB-1:0] d;

        vecs[0] = '{"good A5",      8'hA5, 1'b0, 0, 0, 1, 0, 8'hA5};
        vecs[1] = '{"stop high 5A", 8'h5A, 1'b1, 0, 0, 0, 1, 8'hA5};
        vecs[2] = '{"glitch4 A5",   8'hA5, 1'b0, 4, 0, 1, 0, 8'hA5};
        vecs[3] = '{"glitch6 bit7", 8'hA5, 1'b0, 0, 6, 1, 0, 8'h25};

        rst_n = 1'b0;
        rx_in = IDLE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset code", int'(code), 0);
        checkOutput("reset code_valid", int'(code_valid), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            stim.delete();
            addIdle(5);
            addFrame(vecs[v].data, vecs[v].stop_bit, vecs[v].ninv_all, vecs[v].ninv_b7);
            addIdle(120);
            applyStimulus();
            checkOutput($sformatf("%s valid pulses", vecs[v].name), countKind(1'b0), vecs[v].exp_valid);
            checkOutput($sformatf("%s err pulses", vecs[v].name), countKind(1'b1), vecs[v].exp_err);
            checkOutput($sformatf("%s code", vecs[v].name), int'(code), int'(vecs[v].exp_code));
            checkOutput($sformatf("%s busy after", vecs[v].name), int'(busy), 0);
            compareWithModel(vecs[v].name);
        end

        // False start: three high samples, then idle
        evq.delete();
        @(posedge clk);
        #1;
        t0 = cyc;
        rx_in = ~IDLE;
        repeat (3 * CLK_DIV) @(posedge clk);
        #1;
        rx_in = IDLE;
        while (cyc < t0 + 33) begin
            @(posedge clk);
            #1;
        end
        checkOutput("false start busy during window", int'(busy), 1);
        while (cyc < t0 + 44) begin
            @(posedge clk);
            #1;
        end
        checkOutput("false start busy after window", int'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("false start strobes", evq.size(), 0);

        stim.delete();
        addIdle(3);
        addFrame(8'h3C, 1'b0, 0, 0);
        addIdle(120);
        applyStimulus();
        checkOutput("after false start code", int'(code), 8'h3C);
        compareWithModel("after false start");

        // Back-to-back frames with no idle gap
        stim.delete();
        addIdle(3);
        addFrame(8'h01, 1'b0, 0, 0);
        addFrame(8'hFF, 1'b0, 0, 0);
        addIdle(120);
        applyStimulus();
        compareWithModel("back-to-back");
        checkOutput("back-to-back pulses", evq.size(), 2);
        if (evq.size() >= 2) begin
            checkOutput("back-to-back spacing", evq[1].cyc - evq[0].cyc, SPB * (CB + 2) * CLK_DIV);
            checkOutput("back-to-back first code", int'(evq[0].code), 8'h01);
            checkOutput("back-to-back second code", int'(evq[1].code), 8'hFF);
        end

        // Reset pulse in the middle of data bit 3
        checkOutput("code before reset", int'(code), 8'hFF);
        stim.delete();
        addIdle(2);
        addFrame(8'h77, 1'b0, 0, 0);
        evq.delete();
        @(posedge clk);
        #1;
        driveSlots(0, 2 + SPB + 3 * SPB + 5);
        rst_n = 1'b0;
        rx_in = IDLE;
        #1;
        checkOutput("mid-frame reset code", int'(code), 0);
        checkOutput("mid-frame reset busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (120 * CLK_DIV) @(posedge clk);
        #1;
        checkOutput("mid-frame reset strobes", evq.size(), 0);
        stim.delete();
        addIdle(3);
        addFrame(8'h77, 1'b0, 0, 0);
        addIdle(120);
        applyStimulus();
        checkOutput("after reset code", int'(code), 8'h77);
        compareWithModel("after reset");

        // Line stuck active for 250 samples, then released
        stim.delete();
        addIdle(2);
        for (int i = 0; i < 250; i++) stim.push_back(~IDLE);
        addIdle(130);
        applyStimulus();
        checkOutput("stuck line err pulses", countKind(1'b1), 2);
        checkOutput("stuck line valid pulses", countKind(1'b0), 1);
        checkOutput("stuck line final code", int'(code), 8'hF0);
        compareWithModel("stuck line");

        // Randomized frames with glitches, odd stop bits and noisy gaps
        stim.delete();
        addIdle(4);
        for (int f = 0; f < 10; f++) begin
            d = CB'($urandom_range(0, 255));
            addWindowFlips(~IDLE, $urandom_range(0, 3));
            for (int b = CB - 1; b >= 0; b--) addWindowFlips(d[b], $urandom_range(0, 4));
            addWindowFlips(($urandom_range(0, 5) == 0) ? ~IDLE : IDLE, $urandom_range(0, 3));
            for (int g = $urandom_range(0, 12); g > 0; g--)
                stim.push_back(($urandom_range(0, 9) == 0) ? ~IDLE : IDLE);
        end
        addIdle(120);
        applyStimulus();
        compareWithModel("random");
        checkOutput("random busy after", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oversampled_frame_rx.md
Name: oversampled_frame_rx

Overview:
- Parameterised successor to the fixed 40 kHz sampler/decoder chain. One block generates the sample tick from the system clock and oversamples a serial line.
- Each frame is start bit, CODE_BITS data bits, stop bit. Every bit is recovered by majority vote over SAMPLES_PER_BIT samples.
- Delivers a CODE_BITS-wide code with a one-cycle valid strobe and a framing-error strobe. Feeds the display/consumer logic downstream.

Parameters:
- CLK_DIV, 1250, system clocks per sample tick (50 MHz / 1250 = 40 kHz); legal range ≥2.
- SAMPLES_PER_BIT, 10, samples per bit window; legal range ≥3.
- CODE_BITS, 8, data bits per frame; legal range 1..32.
- IDLE_LEVEL, 0, line level when idle and during the stop bit. The start bit is ~IDLE_LEVEL.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_in  in  1  raw asynchronous serial line.
- code  out  CODE_BITS  last good decoded word.
- code_valid  out  1  one-cycle pulse; code updated this cycle.
- frame_err  out  1  one-cycle pulse; frame rejected (bad stop bit).
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async assert, sync release):
  - code=0, code_valid=0, frame_err=0, busy=0.
  - State=IDLE; tick counter, sample counter, ones counter, bit counter and shift register all cleared.
  - Synchroniser flops are set to IDLE_LEVEL.
- Input path: 2-flop synchroniser on rx_in; all decisions use the synchronised signal rx_s.
- Tick: a free-running counter 0..CLK_DIV-1 asserts tick for one clock when it wraps to 0. It runs in every state and is never restarted by a frame.
- Votes: each tick adds rx_s to the ones counter (width clog2(SAMPLES_PER_BIT+1)). When sample_cnt reaches SAMPLES_PER_BIT-1 the window closes.
  - bit = (ones > SAMPLES_PER_BIT/2), using integer division, so even-count ties resolve to 0.
  - The vote result is XOR-normalised against IDLE_LEVEL only for the start/stop checks. Data bits are taken raw.
- State machine, advancing only on tick:
  - IDLE: when rx_s != IDLE_LEVEL on a tick, go to START. That tick counts as sample 0 (ones preloaded accordingly, sample_cnt=1).
  - START: at window close, go to DATA if the vote equals ~IDLE_LEVEL. Otherwise it is a false start: return to IDLE with no strobe.
  - DATA: at each window close, shift the vote in MSB-first. After CODE_BITS windows, go to STOP.
  - STOP: at window close, if the vote == IDLE_LEVEL, load code from the shift register and pulse code_valid. Otherwise pulse frame_err and leave code unchanged. Go to IDLE in both cases.
- Latency: code_valid/frame_err assert on the clock edge following the tick that closes the stop window. Total latency is (CODE_BITS+2)*SAMPLES_PER_BIT ticks from the start tick, plus 1 clock.
- code_valid and frame_err are never high together. Each pulse is exactly 1 clock wide.
- A new start is recognised no earlier than the first tick after returning to IDLE. Back-to-back frames with no idle gap are accepted.
- Counters and vote logic are reset at each window close; there is no accumulation across windows.
- rst_n asserted mid-frame aborts the frame immediately: no strobe, code returns to 0.
- Line stuck at ~IDLE_LEVEL: the start window is accepted, data bits decode as all ones (or all zeros if IDLE_LEVEL=1), the stop check fails, and frame_err pulses. The block then re-enters START on the next tick and repeats, giving one frame_err per frame period.

Decomposition:
- Shared package holds:
  - state enum {IDLE, START, DATA, STOP};
  - a clog2-style width helper;
  - default constants CLK_DIV_40K=1250, SAMPLES_PER_BIT_DEF=10, CODE_BITS_DEF=8.
- One natural sub-module: tick_divider (parameter DIV; ports CLOCK_50, rst_n, tick), replacing the standalone clock generator. The synchroniser and majority voter stay inline.

Test Plan:
- Good frame: sim with CLK_DIV=4, SPB=10, CODE_BITS=8, IDLE_LEVEL=0; send start=1, data 0xA5 MSB-first, stop=0, each bit held 40 clocks -> single code_valid pulse, code=0xA5, frame_err never high, busy low afterwards.
- Glitch tolerance: same frame with 4 of 10 samples inverted in every bit window -> code=0xA5; with 6 inverted in bit 7 only -> code=0x25.
- False start: 1-high pulse of 12 clocks (3 samples) then idle -> no strobe, busy returns low after 10 ticks, the following 0x3C frame decodes correctly.
- Framing error: 0x5A frame with stop bit high -> frame_err pulse, no code_valid, code keeps its previous value (0xA5).
- Back-to-back frames: 0x01 then 0xFF with no idle gap -> two code_valid pulses exactly 10*10*4 clocks apart, codes 0x01 then 0xFF.
- Reset mid-frame: assert rst_n low during data bit 3 for 1 clock -> code=0, busy=0 immediately, no strobe; the next full 0x77 frame decodes correctly.
